xy_router_sync: RTL and testbench

- Synchronous, parametrised successor to the asynchronous corner/edge routers. One block covers every mesh position: corner, edge and centre.
- NPORTS req/ack/data channels, with index 0 the local processor. Each input has a FIFO. Routing is dimension-ordered XY from header coordinates. Each output has a round-robin arbiter and a registered output stage.
- Sits between a processing element and its mesh neighbours. Ports absent at a mesh boundary are tied off: `in_req=0`, `out_ack=0`.

---
 rtl/xy_router_sync.sv | 187 ++++++++++++++++++
 tb/tb_xy_router_sync.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_router_sync.sv
// ---------------------------------------------------------------------------
// xy_router_sync
//
// Synchronous mesh router usable at any mesh position (corner, edge, centre).
// Every input channel owns a DEPTH-entry FIFO; the FIFO head is routed
// dimension-ordered (X first, then Y) from the destination coordinates held
// in the top bits of the flit. Every output owns a round-robin arbiter and a
// registered output stage, so a free path forwards one flit per cycle.
//
// Channel index map: 0=local, 1=north (y+1), 2=east (x+1), 3=south (y-1),
// 4=west (x-1). Channels missing at a mesh boundary are tied off outside the
// block (in_req=0, out_ack=0).
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_req    per-input valid
//   in_ack    per-input ready (registered, high while the FIFO has room)
//   in_data   per-input flit, channel p at [p*N +: N]
//   out_req   per-output valid (registered)
//   out_ack   per-output ready
//   out_data  per-output flit, channel p at [p*N +: N]
// A transfer happens on a rising edge where req && ack.
// ---------------------------------------------------------------------------
module xy_router_sync #(
    parameter int NPORTS = 5,
    parameter int N      = 32,
    parameter int MAXX   = 2,
    parameter int MAXY   = 2,
    parameter int SRCX   = 0,
    parameter int SRCY   = 0,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORTS-1:0]   in_req,
    output logic [NPORTS-1:0]   in_ack,
    input  logic [NPORTS*N-1:0] in_data,
    output logic [NPORTS-1:0]   out_req,
    input  logic [NPORTS-1:0]   out_ack,
    output logic [NPORTS*N-1:0] out_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [MAXX-1:0] SRC_X      = MAXX'(SRCX);
    localparam logic [MAXY-1:0] SRC_Y      = MAXY'(SRCY);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST_PORT  = PW'(NPORTS - 1);

    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_WEST  = 4;

    // Input FIFO storage and bookkeeping
    logic [N-1:0]    mem        [NPORTS][DEPTH];
    logic [AW-1:0]   wr_ptr     [NPORTS];
    logic [AW-1:0]   rd_ptr     [NPORTS];
    logic [CW-1:0]   count      [NPORTS];
    logic [CW-1:0]   count_next [NPORTS];
    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] empty;

    // Routing of each FIFO head
    logic [N-1:0]    head  [NPORTS];
    logic [MAXX-1:0] dst_x [NPORTS];
    logic [MAXY-1:0] dst_y [NPORTS];
    logic [PW-1:0]   route [NPORTS];

    // Per-output arbitration
    logic [PW-1:0]     rr_ptr    [NPORTS];
    logic [NPORTS-1:0] grant_valid;
    logic [PW-1:0]     grant_idx [NPORTS];

    // in_ack is a register, so a push never depends combinationally on in_req
    // through the ready path.
    assign push = in_req & in_ack;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path through the block leaves a latch.
    always_comb begin
        int dir;
        dir = PORT_LOCAL;
        for (int p = 0; p < NPORTS; p++) begin
            head[p]  = mem[p][rd_ptr[p]];
            dst_x[p] = head[p][N-1 -: MAXX];
            dst_y[p] = head[p][N-MAXX-1 -: MAXY];
            empty[p] = (count[p] == '0);

            if (dst_x[p] > SRC_X)      dir = PORT_EAST;
            else if (dst_x[p] < SRC_X) dir = PORT_WEST;
            else if (dst_y[p] > SRC_Y) dir = PORT_NORTH;
            else if (dst_y[p] < SRC_Y) dir = PORT_SOUTH;
            else                       dir = PORT_LOCAL;

            // A reduced-port build may compute a channel it lacks; such
            // flits are delivered locally instead of being lost.
            if (dir >= NPORTS) dir = PORT_LOCAL;
            route[p] = PW'(dir);
        end
    end

    // Round-robin arbiters. An output may only take a new flit when its
    // register is empty or is being drained on this same edge.
    always_comb begin
        int idx;
        idx = 0;
        pop = '0;
        for (int o = 0; o < NPORTS; o++) begin
            grant_valid[o] = 1'b0;
            grant_idx[o]   = '0;
            if (!out_req[o] || out_ack[o]) begin
                for (int k = 0; k < NPORTS; k++) begin
                    idx = int'(rr_ptr[o]) + k;
                    if (idx >= NPORTS) idx = idx - NPORTS;
                    if (!grant_valid[o] && !empty[idx] && route[idx] == PW'(o)) begin
                        grant_valid[o] = 1'b1;
                        grant_idx[o]   = PW'(idx);
                    end
                end
            end
            // Each head has a single route, so at most one output pops it.
            if (grant_valid[o]) pop[grant_idx[o]] = 1'b1;
        end
    end

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            count_next[p] = count[p] + CW'(push[p]) - CW'(pop[p]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
            in_ack <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
                count[p]  <= count_next[p];
                in_ack[p] <= (count_next[p] < FULL_COUNT);
            end
        end
    end

    // NOTE: the FIFO storage has no reset; emptiness is defined by count,
    // so stale entries are unreachable after reset and the array can map to RAM.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*N +: N];
        end
    end

    // Output registers: a grant reloads on the same edge as a drain, which
    // sustains one flit per cycle per output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_req  <= '0;
            out_data <= '0;
            for (int o = 0; o < NPORTS; o++) rr_ptr[o] <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (grant_valid[o]) begin
                    out_req[o]         <= 1'b1;
                    out_data[o*N +: N] <= head[grant_idx[o]];
                    rr_ptr[o]          <= (grant_idx[o] == LAST_PORT) ? '0
                                                                      : grant_idx[o] + PW'(1);
                end else if (out_ack[o]) begin
                    out_req[o] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xy_router_sync.sv
// ---------------------------------------------------------------------------
// tb_xy_router_sync
//
// Bench for a centre router at (1,1) with 2-bit coordinates, 32-bit flits and
// 4-entry FIFOs. Directed steps cover reset, basic routing, XY ordering,
// loopback, contention, backpressure and mid-traffic reset; a random soak
// then pushes 10k flits. Every accepted flit is recorded in a pending list
// with the output its destination implies; every emitted flit must match a
// pending flit for that output with no older flit on the same input->output
// path still waiting.
// ---------------------------------------------------------------------------
module tb_xy_router_sync;

    localparam int NP = 5;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   in_req;
    logic [NP-1:0]   in_ack;
    logic [NP*W-1:0] in_data;
    logic [NP-1:0]   out_req;
    logic [NP-1:0]   out_ack;
    logic [NP*W-1:0] out_data;

    xy_router_sync #(
        .NPORTS(NP), .N(W), .MAXX(2), .MAXY(2), .SRCX(1), .SRCY(1), .DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_req  (in_req),
        .in_ack  (in_ack),
        .in_data (in_data),
        .out_req (out_req),
        .out_ack (out_ack),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           src;
        int           dst;
        logic [W-1:0] data;
    } flit_t;

    flit_t       pend[$];
    int          checks     = 0;
    int          failures   = 0;
    int          emit_count = 0;
    int          acc_total  = 0;
    logic [NP-1:0] acc      = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Destination port of a flit as seen from router (1,1): X first, then Y.
    function automatic int route_of(input logic [W-1:0] f);
        int x;
        int y;
        x = int'(f[31:30]);
        y = int'(f[29:28]);
        if (x > 1) return 2;
        if (x < 1) return 4;
        if (y > 1) return 1;
        if (y < 1) return 3;
        return 0;
    endfunction

    task automatic check_emit(input int o, input logic [W-1:0] d);
        int found;
        bit in_order;
        found    = -1;
        in_order = 1'b1;
        for (int i = 0; i < pend.size(); i++) begin
            if (found < 0 && pend[i].dst == o && pend[i].data == d) found = i;
        end
        if (found >= 0) begin
            for (int j = 0; j < found; j++) begin
                if (pend[j].src == pend[found].src && pend[j].dst == o) in_order = 1'b0;
            end
        end
        check($sformatf("emit_port%0d_data%08h", o, d), 64'(found >= 0 && in_order), 64'd1);
        if (found >= 0) pend.delete(found);
        emit_count++;
    endtask

    // Called right after a falling edge with inputs already driven. Records
    // the transfers that the coming rising edge performs, then returns at the
    // next falling edge.
    task automatic tick();
        flit_t f;
        #1;
        acc = in_req & in_ack;
        for (int o = 0; o < NP; o++) begin
            if (out_req[o] && out_ack[o]) check_emit(o, out_data[o*W +: W]);
        end
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                f.src  = p;
                f.data = in_data[p*W +: W];
                f.dst  = route_of(f.data);
                pend.push_back(f);
                acc_total++;
            end
        end
        @(negedge clk);
    endtask

    task automatic single(input int src, input logic [W-1:0] f, input int dst, input string tag);
        out_ack             = '1;
        in_req[src]         = 1'b1;
        in_data[src*W +: W] = f;
        tick();
        in_req[src] = 1'b0;
        check({tag, "_idle"}, 64'(out_req), 64'd0);
        tick();
        check({tag, "_req"},  64'(out_req), 64'(5'(1 << dst)));
        check({tag, "_data"}, 64'(out_data[dst*W +: W]), 64'(f));
        tick();
    endtask

    initial begin
        int          srcs [3];
        int          acc0;
        int          emit0;
        int          seq;
        int          sent;
        logic [W-1:0] bp_data;
        logic [W-1:0] f;

        srcs = '{0, 1, 4};

        // ---------------- reset ----------------
        rst     = 1'b1;
        in_req  = '0;
        out_ack = '0;
        in_data = '0;
        #1 rst = 1'b0;
        #2;
        check("reset_in_ack",   64'(in_ack),  64'd0);
        check("reset_out_req",  64'(out_req), 64'd0);
        check("reset_out_data", 64'(out_data == '0), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 check("in_ack_before_edge", 64'(in_ack), 64'd0);
        @(negedge clk);
        check("in_ack_after_edge", 64'(in_ack), 64'h1f);

        // ---------------- contention: local, north, west -> east ----------------
        for (int b = 0; b < 2; b++) begin
            out_ack = '1;
            for (int i = 0; i < 3; i++) begin
                in_req[srcs[i]]         = 1'b1;
                in_data[srcs[i]*W +: W] = 32'h8000_0000 | (b << 8) | srcs[i];
            end
            tick();
            in_req = '0;
            for (int i = 0; i < 3; i++) begin
                tick();
                check($sformatf("burst%0d_slot%0d_req", b, i), 64'(out_req), 64'h04);
                check($sformatf("burst%0d_slot%0d_data", b, i), 64'(out_data[2*W +: W]),
                      64'(32'h8000_0000 | (b << 8) | srcs[i]));
            end
            tick();
        end

        // ---------------- basic route, XY order, loopback ----------------
        single(0, 32'h9ABC_0001, 2, "basic_east");
        single(4, 32'h7000_0A04, 1, "west_to_north");
        single(1, 32'h4000_0B01, 3, "north_to_south");
        single(0, 32'h5000_0C00, 0, "local_loopback");

        // ---------------- backpressure ----------------
        out_ack = '0;
        acc0    = acc_total;
        emit0   = emit_count;
        bp_data = 32'hC000_0000;
        in_req[0]     = 1'b1;
        in_data[0+:W] = bp_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (acc[0]) begin
                bp_data       = bp_data + 1;
                in_data[0+:W] = bp_data;
            end
        end
        check("bp_accepted", 64'(acc_total - acc0), 64'd5);
        check("bp_in_ack_low", 64'(in_ack[0]), 64'd0);
        out_ack[2] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (acc[0]) in_req[0] = 1'b0;
        end
        check("bp_drained", 64'(emit_count - emit0), 64'd6);
        check("bp_in_ack_back", 64'(in_ack[0]), 64'd1);
        check("bp_nothing_left", 64'(pend.size()), 64'd0);

        // ---------------- reset mid-traffic ----------------
        out_ack = '0;
        for (int i = 0; i < 3; i++) begin
            in_req[0]     = 1'b1;
            in_data[0+:W] = 32'hC000_0100 + i;
            tick();
        end
        in_req[0] = 1'b0;
        tick();
        check("pre_reset_req", 64'(out_req), 64'h04);
        rst = 1'b0;
        #1;
        check("mid_reset_out_req",  64'(out_req), 64'd0);
        check("mid_reset_in_ack",   64'(in_ack),  64'd0);
        check("mid_reset_out_data", 64'(out_data == '0), 64'd1);
        pend.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_reset_in_ack", 64'(in_ack), 64'h1f);
        out_ack = '1;
        emit0   = emit_count;
        repeat (4) tick();
        check("post_reset_no_stale", 64'(emit_count - emit0), 64'd0);
        check("post_reset_out_req",  64'(out_req), 64'd0);
        single(0, 32'h9ABC_0002, 2, "post_reset_east");

        // ---------------- random soak ----------------
        in_req = '0;
        acc    = '0;
        acc0   = acc_total;
        sent   = 0;
        seq    = 0;
        for (int cyc = 0; cyc < 40000 && (sent < 10000 || in_req != '0); cyc++) begin
            for (int p = 0; p < NP; p++) begin
                if (!in_req[p] || acc[p]) begin
                    if (sent < 10000 && $urandom_range(3) != 0) begin
                        f = {2'($urandom), 2'($urandom), 4'($urandom), 24'(seq)};
                        seq++;
                        in_req[p]         = 1'b1;
                        in_data[p*W +: W] = f;
                        sent++;
                    end else begin
                        in_req[p] = 1'b0;
                    end
                end
            end
            out_ack = NP'($urandom);
            tick();
        end
        in_req  = '0;
        out_ack = '1;
        for (int i = 0; i < 200 && pend.size() != 0; i++) tick();
        check("soak_all_accepted", 64'(acc_total - acc0), 64'd10000);
        check("soak_no_loss", 64'(pend.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
